lb_idle_fill_fifo: RTL and testbench
====================================

LB_IDLE_FILL_FIFO -- requirements
Module: lb_idle_fill_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 8, FIFO depth in 72-bit words (power of 2, 4..64).
REQ-002 SHALL have parameter START_THRESH, default 4, minimum FIFO occupancy before a start word is dequeued (1..DEPTH).
REQ-003 SHALL have port clk  input  1  sole clock; all logic is rising-edge clk.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  upstream word valid.
REQ-006 SHALL have port in_ready  output  1  FIFO can accept; equals (level != DEPTH), combinational from registered level.
REQ-007 SHALL have port in_data  input  72  word: [63:0] data lanes 0..7, [71:64] ctrl, ctrl bit i flags byte i.
REQ-008 SHALL have port out_valid  output  1  output word valid, registered.
REQ-009 SHALL have port out_ready  input  1  downstream accepts; loopback timing adapter drives it constant 1.
REQ-010 SHALL have port out_data  output  72  registered output word, same layout as in_data.
REQ-011 SHALL have port level  output  clog2(DEPTH)+1  current FIFO occupancy.
REQ-012 SHALL have ports idle_cnt, underrun_cnt  output  16 each  statistics (see Configuration).

Function
REQ-013 SHALL write in_data into the FIFO on each edge where in_valid && in_ready; no write when full.
REQ-014 SHALL hold out_data and FIFO head unchanged on edges where out_ready=0.
REQ-015 SHALL, on each edge with out_ready=1, load out_data from exactly one source: FIFO head (popped), IDLE word, or ERROR word.
REQ-016 IDLE word SHALL be data 0x0707070707070707, ctrl 0xFF; ERROR word SHALL be data 0xFEFEFEFEFEFEFEFE, ctrl 0xFF.
REQ-017 Start word SHALL be ctrl[0]=1 and data[7:0]=0xFB; terminate word SHALL be any byte i with ctrl[i]=1 and byte=0xFD.
REQ-018 SHALL implement two states, GAP and FRAME; reset state GAP.
REQ-019 GAP: head non-start and level>=1 -> pop, stay GAP; head start and level>=START_THRESH -> pop, go FRAME; otherwise emit IDLE.
REQ-020 FRAME: level>=1 -> pop; popped word containing terminate -> go GAP, else stay FRAME.
REQ-021 FRAME with level=0 (underrun) -> emit ERROR, go GAP, increment underrun_cnt; subsequent words of that frame are forwarded as non-start words in GAP.
REQ-022 A start word popped in FRAME SHALL be forwarded unchanged and remain in FRAME.
REQ-023 Word written at edge N into empty FIFO, GAP state, START_THRESH=1, out_ready=1 SHALL appear on out_data after edge N+1.
REQ-024 Simultaneous push and pop SHALL leave level unchanged; push when full is blocked by in_ready=0 even if a pop occurs that edge.
REQ-025 Read/write pointers SHALL wrap modulo DEPTH with no lost or duplicated words.
REQ-026 out_valid SHALL be 0 in reset and 1 from the first edge after reset deassertion.

Reset
REQ-027 Asserting reset SHALL immediately force: level=0, pointers=0, state=GAP, out_valid=0, out_data=IDLE word, idle_cnt=0, underrun_cnt=0.
REQ-028 Reset mid-frame SHALL discard all FIFO contents; no partial frame is emitted after release.
REQ-029 in_ready SHALL be 1 during and immediately after reset.

Configuration
REQ-030 Macro LB_IDLE_FILL_STATS_EN defined: idle_cnt increments (saturating at 0xFFFF) per IDLE word emitted; underrun_cnt increments (saturating) per REQ-021 event.
REQ-031 Macro LB_IDLE_FILL_STATS_EN undefined: counter registers omitted, idle_cnt and underrun_cnt tied to 0; datapath behaviour identical.

Verification
REQ-032 Reset release, in_valid=0 for 10 cycles -> out_valid=1, out_data=IDLE every cycle, idle_cnt=10 (stats on).
REQ-033 START_THRESH=4: push start word then 1 word per 3 cycles -> start withheld (IDLE out) until level=4, then frame streams in order.
REQ-034 8-word frame (start..terminate) pushed back-to-back at DEPTH=8, out_ready=0 for 8 cycles -> in_ready=0 at level=8, then release yields all 8 words unchanged.
REQ-035 Frame stalls after 3 data words while in FRAME -> ERROR word output once, underrun_cnt=1, state GAP, later words forwarded.
REQ-036 100 cycles random in_valid and out_ready, non-start words only -> output word sequence equals input sequence with IDLE fill, pointers wrap cleanly.
REQ-037 Reset asserted mid-frame with level=5 -> level=0, out_data=IDLE asynchronously; after release no stale word appears.

Source files
------------

// File: rtl/lb_idle_fill_fifo_if.sv
// lb_idle_fill_fifo_if: upstream write handshake plus registered output port of lb_idle_fill_fifo.
// Words are 72 bits: [63:0] eight data lanes, [71:64] per-lane control flags.
interface lb_idle_fill_fifo_if;
    logic        in_valid;
    logic        in_ready;
    logic [71:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [71:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/lb_idle_fill_fifo.sv
// lb_idle_fill_fifo: loopback FIFO that fills inter-frame gaps with IDLE and marks mid-frame underruns
// with an ERROR word. Define LB_IDLE_FILL_STATS_EN to build the idle/underrun statistics counters.
module lb_idle_fill_fifo #(
    parameter int DEPTH        = 8,
    parameter int START_THRESH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    lb_idle_fill_fifo_if.slave     bus,
    output logic [$clog2(DEPTH):0] level,
    output logic [15:0]            idle_cnt,
    output logic [15:0]            underrun_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LVL   = LW'(DEPTH);
    localparam logic [LW-1:0] THRESH_LVL = LW'(START_THRESH);
    localparam logic [71:0]   IDLE_WORD  = {8'hFF, 64'h0707_0707_0707_0707};
    localparam logic [71:0]   ERROR_WORD = {8'hFF, 64'hFEFE_FEFE_FEFE_FEFE};

    typedef enum logic {GAP = 1'b0, FRAME = 1'b1} state_t;
    typedef enum logic [1:0] {SRC_HEAD = 2'd0, SRC_IDLE = 2'd1, SRC_ERROR = 2'd2} src_t;

    logic [71:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] level_q;
    state_t        state;
    state_t        state_nxt;
    src_t          src;
    logic          push;
    logic          pop;
    logic          in_ready_int;
    logic          level_nz;
    logic          head_start;
    logic          head_term;
    logic [71:0]   head;
    logic [71:0]   word_nxt;
    logic          vld_p1;
    logic [71:0]   data_p1;

    function automatic logic is_start(input logic [71:0] w);
        return w[64] && (w[7:0] == 8'hFB);
    endfunction

    function automatic logic has_term(input logic [71:0] w);
        logic t;
        t = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (w[64+i] && (w[8*i +: 8] == 8'hFD)) t = 1'b1;
        end
        return t;
    endfunction

    assign in_ready_int = (level_q != FULL_LVL);
    assign push         = bus.in_valid && in_ready_int;
    assign level_nz     = (level_q != '0);
    assign head         = mem[rd_ptr];
    assign head_start   = is_start(head);
    assign head_term    = has_term(head);

    // Storage array carries no reset; occupancy and pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.in_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= GAP;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (bus.out_ready) begin
            case (state)
                GAP: begin
                    if (head_start && level_q >= THRESH_LVL) state_nxt = FRAME;
                end
                FRAME: begin
                    // An empty FIFO mid-frame ends the frame; its tail arrives later as gap traffic.
                    if (!level_nz || head_term) state_nxt = GAP;
                end
                default: state_nxt = GAP;
            endcase
        end
    end

    always_comb begin
        pop = 1'b0;
        src = SRC_IDLE;
        if (bus.out_ready) begin
            case (state)
                GAP: begin
                    if ((level_nz && !head_start) || (head_start && level_q >= THRESH_LVL)) begin
                        pop = 1'b1;
                        src = SRC_HEAD;
                    end
                end
                FRAME: begin
                    if (level_nz) begin
                        pop = 1'b1;
                        src = SRC_HEAD;
                    end else begin
                        src = SRC_ERROR;
                    end
                end
                default: src = SRC_IDLE;
            endcase
        end
    end

    always_comb begin
        case (src)
            SRC_HEAD:  word_nxt = head;
            SRC_ERROR: word_nxt = ERROR_WORD;
            default:   word_nxt = IDLE_WORD;
        endcase
    end

    // Output register stage: one word per accepted cycle, held while downstream stalls.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p1  <= 1'b0;
            data_p1 <= IDLE_WORD;
        end else begin
            vld_p1 <= 1'b1;
            if (bus.out_ready) data_p1 <= word_nxt;
        end
    end

    assign bus.in_ready  = in_ready_int;
    assign bus.out_valid = vld_p1;
    assign bus.out_data  = data_p1;
    assign level         = level_q;

`ifdef LB_IDLE_FILL_STATS_EN
    logic idle_evt;
    logic underrun_evt;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign idle_evt     = bus.out_ready && (src == SRC_IDLE);
    assign underrun_evt = bus.out_ready && (src == SRC_ERROR);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idle_cnt     <= '0;
            underrun_cnt <= '0;
        end else begin
            if (idle_evt)     idle_cnt     <= sat_inc(idle_cnt);
            if (underrun_evt) underrun_cnt <= sat_inc(underrun_cnt);
        end
    end
`else
    assign idle_cnt     = '0;
    assign underrun_cnt = '0;
`endif

endmodule

// File: tb/tb_lb_idle_fill_fifo.sv
// tb_lb_idle_fill_fifo: directed vectors for lb_idle_fill_fifo (DEPTH=8, START_THRESH=4)
// plus a short randomized gap-traffic run checked against a queue model.
`timescale 1ns/1ps
module tb_lb_idle_fill_fifo;

    localparam int DEPTH        = 8;
    localparam int START_THRESH = 4;
    localparam logic [71:0] IDLE_W = {8'hFF, 64'h0707_0707_0707_0707};
    localparam logic [71:0] ERR_W  = {8'hFF, 64'hFEFE_FEFE_FEFE_FEFE};
`ifdef LB_IDLE_FILL_STATS_EN
    localparam logic [15:0] EXP_IDLE10 = 16'd10;
    localparam logic [15:0] EXP_UNDER1 = 16'd1;
`else
    localparam logic [15:0] EXP_IDLE10 = 16'd0;
    localparam logic [15:0] EXP_UNDER1 = 16'd0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  level;
    logic [15:0] idle_cnt;
    logic [15:0] underrun_cnt;
    int          n_checks = 0;
    int          n_fail   = 0;

    lb_idle_fill_fifo_if bus();

    lb_idle_fill_fifo #(.DEPTH(DEPTH), .START_THRESH(START_THRESH)) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .level        (level),
        .idle_cnt     (idle_cnt),
        .underrun_cnt (underrun_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [71:0] start_w;
    logic [71:0] term_w;
    logic [71:0] w1;
    logic [71:0] f [8];
    logic [71:0] d4 [4];
    logic [71:0] a6 [4];
    logic [71:0] a4;
    logic [71:0] n1;
    logic [71:0] xw;
    logic [71:0] z;
    logic [71:0] q [$];
    logic [71:0] exp_out;
    int          mlevel;
    int          seq;
    logic        do_push;
    logic        do_pop;

    initial begin
        start_w = {8'h01, 64'h5555_5555_5555_55FB};
        term_w  = {8'h80, 64'hFD00_1122_3344_5566};
        w1      = {8'h00, 64'h0123_4567_89AB_CDEF};
        a4      = {8'h00, 64'hA4A4_A4A4_A4A4_A4A4};
        n1      = {8'h00, 64'h4E31_4E31_4E31_4E31};
        xw      = {8'h00, 64'hDEAD_DEAD_DEAD_DEAD};
        z       = {8'h00, 64'h7A7A_0000_7A7A_0000};
        f[0] = start_w;
        f[7] = term_w;
        for (int i = 1; i < 7; i++) f[i] = {8'h00, 64'(i) * 64'h0101_0101_0101_0101};
        d4[0] = start_w;
        d4[1] = {8'h00, 64'hD1D1_D1D1_D1D1_D1D1};
        d4[2] = {8'h00, 64'hD2D2_D2D2_D2D2_D2D2};
        d4[3] = term_w;
        a6[0] = start_w;
        a6[1] = {8'h00, 64'hA1A1_A1A1_A1A1_A1A1};
        a6[2] = {8'h00, 64'hA2A2_A2A2_A2A2_A2A2};
        a6[3] = {8'h00, 64'hA3A3_A3A3_A3A3_A3A3};

        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;

        // Reset state, forced immediately and held through clock edges
        #1;
        check_eq("rst_level", 72'(level), 72'(0));
        check_eq("rst_out_valid", 72'(bus.out_valid), 72'(0));
        check_eq("rst_out_data", bus.out_data, IDLE_W);
        check_eq("rst_in_ready", 72'(bus.in_ready), 72'(1));
        step();
        step();
        check_eq("rst_hold_valid", 72'(bus.out_valid), 72'(0));
        check_eq("rst_idle_cnt", 72'(idle_cnt), 72'(0));
        check_eq("rst_underrun_cnt", 72'(underrun_cnt), 72'(0));
        reset = 1'b0;

        // Idle fill after release
        for (int i = 0; i < 10; i++) begin
            step();
            check_eq("idle_valid", 72'(bus.out_valid), 72'(1));
            check_eq("idle_data", bus.out_data, IDLE_W);
        end
        check_eq("idle_cnt10", 72'(idle_cnt), 72'(EXP_IDLE10));
        check_eq("idle_in_ready", 72'(bus.in_ready), 72'(1));

        // Single gap word: written at edge N, visible after edge N+1
        bus.in_valid = 1'b1;
        bus.in_data  = w1;
        step();
        bus.in_valid = 1'b0;
        check_eq("lat_level1", 72'(level), 72'(1));
        check_eq("lat_not_yet", bus.out_data, IDLE_W);
        step();
        check_eq("lat_word", bus.out_data, w1);
        check_eq("lat_level0", 72'(level), 72'(0));

        // Start word withheld until four words are queued
        for (int k = 0; k < 10; k++) begin
            bus.in_valid = (k % 3 == 0);
            bus.in_data  = d4[k/3];
            step();
            check_eq("thr_withheld", bus.out_data, IDLE_W);
        end
        bus.in_valid = 1'b0;
        check_eq("thr_level4", 72'(level), 72'(4));
        for (int k = 0; k < 4; k++) begin
            step();
            check_eq("thr_stream", bus.out_data, d4[k]);
        end
        step();
        check_eq("thr_after", bus.out_data, IDLE_W);

        // Fill to full with output stalled, then drain with overlapping push
        bus.out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = f[i];
            step();
            check_eq("full_level", 72'(level), 72'(i + 1));
            check_eq("full_hold", bus.out_data, IDLE_W);
        end
        check_eq("full_in_ready", 72'(bus.in_ready), 72'(0));
        bus.in_data = xw;
        step();
        check_eq("full_blocked", 72'(level), 72'(8));
        bus.out_ready = 1'b1;
        check_eq("full_in_ready_pop", 72'(bus.in_ready), 72'(0));
        step();
        check_eq("drain_w0", bus.out_data, f[0]);
        check_eq("drain_lvl7", 72'(level), 72'(7));
        bus.in_data = n1;
        step();
        bus.in_valid = 1'b0;
        check_eq("drain_w1", bus.out_data, f[1]);
        check_eq("drain_pushpop_lvl", 72'(level), 72'(7));
        for (int i = 2; i < 8; i++) begin
            step();
            check_eq("drain_w", bus.out_data, f[i]);
            check_eq("drain_lvl", 72'(level), 72'(8 - i));
        end
        step();
        check_eq("drain_n1", bus.out_data, n1);
        step();
        check_eq("drain_idle", bus.out_data, IDLE_W);
        check_eq("drain_empty", 72'(level), 72'(0));

        // Underrun after three data words inside a frame
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = a6[i];
            step();
            check_eq("und_fill", bus.out_data, IDLE_W);
        end
        bus.in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check_eq("und_stream", bus.out_data, a6[i]);
        end
        step();
        check_eq("und_error", bus.out_data, ERR_W);
        check_eq("und_cnt", 72'(underrun_cnt), 72'(EXP_UNDER1));
        step();
        check_eq("und_gap_idle", bus.out_data, IDLE_W);
        bus.in_valid = 1'b1;
        bus.in_data  = a4;
        step();
        bus.in_valid = 1'b0;
        step();
        check_eq("und_late_word", bus.out_data, a4);
        step();
        check_eq("und_still_gap", bus.out_data, IDLE_W);
        check_eq("und_cnt_once", 72'(underrun_cnt), 72'(EXP_UNDER1));

        // Random gap traffic against a queue model
        mlevel  = 0;
        seq     = 0;
        exp_out = IDLE_W;
        for (int c = 0; c < 110; c++) begin
            if (c < 100) begin
                bus.in_valid  = 1'($urandom_range(0, 1));
                bus.out_ready = 1'($urandom_range(0, 1));
            end else begin
                bus.in_valid  = 1'b0;
                bus.out_ready = 1'b1;
            end
            bus.in_data = {8'h00, 32'hC0DE_0000, 32'(seq)};
            do_push = bus.in_valid && (mlevel != DEPTH);
            do_pop  = bus.out_ready && (mlevel > 0);
            check_eq("rnd_in_ready", 72'(bus.in_ready), 72'(mlevel != DEPTH));
            if (bus.out_ready) exp_out = do_pop ? q.pop_front() : IDLE_W;
            if (do_push) begin
                q.push_back(bus.in_data);
                seq++;
            end
            mlevel = mlevel + int'(do_push) - int'(do_pop);
            step();
            check_eq("rnd_out", bus.out_data, exp_out);
            check_eq("rnd_level", 72'(level), 72'(mlevel));
        end

        // Asynchronous reset in the middle of a frame
        bus.out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = (i == 0) ? start_w : {8'h00, 64'(i) * 64'h0B0B_0B0B_0B0B_0B0B};
            step();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check_eq("mid_start_out", bus.out_data, start_w);
        check_eq("mid_level5", 72'(level), 72'(5));
        #3;
        reset = 1'b1;
        #1;
        check_eq("arst_level", 72'(level), 72'(0));
        check_eq("arst_data", bus.out_data, IDLE_W);
        check_eq("arst_valid", 72'(bus.out_valid), 72'(0));
        check_eq("arst_in_ready", 72'(bus.in_ready), 72'(1));
        step();
        reset = 1'b0;
        bus.out_ready = 1'b1;
        check_eq("rel_in_ready", 72'(bus.in_ready), 72'(1));
        for (int i = 0; i < 4; i++) begin
            step();
            check_eq("rel_idle", bus.out_data, IDLE_W);
            check_eq("rel_level", 72'(level), 72'(0));
        end
        bus.in_valid = 1'b1;
        bus.in_data  = z;
        step();
        bus.in_valid = 1'b0;
        step();
        check_eq("rel_new_word", bus.out_data, z);
        step();
        check_eq("rel_no_stale", bus.out_data, IDLE_W);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
